// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer
//
// Registered front/back end wrapped around a combinational ALU. Operations
// arrive over a valid/ready handshake and are buffered in a small FIFO. One
// operation per cycle is issued from the FIFO head to the ALU, and the ALU's
// answer is captured into an output register that is drained over a second
// valid/ready handshake.
//
// Parameters:
//   SIZE   operand width (must match the attached alu instance)
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         operation handshake (in_ready = count != DEPTH)
//   in_command, in_a, in_b      operation fields
//   alu_enable                  high only in issue cycles
//   alu_command, alu_a, alu_b   FIFO head fields, 0 when the FIFO is empty
//   alu_result, alu_overflow    combinational answer from the ALU
//   out_valid / out_ready       result handshake
//   out_result, out_overflow    captured ALU answer
//   out_command                 command that produced out_result
//   out_error                   command rejected by the optional check
//
// Build option:
//   ALU_SEQ_CMD_CHECK_EN  when defined, commands 12..15 are not forwarded to
//                         the ALU; they consume an issue slot and produce a
//                         zero result with out_error set. When undefined,
//                         every command is forwarded and out_error is 0.
// ============================================================================
module alu_sequencer #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_command,
    input  logic [SIZE-1:0]     in_a,
    input  logic [SIZE-1:0]     in_b,

    output logic                alu_enable,
    output logic [3:0]          alu_command,
    output logic [SIZE-1:0]     alu_a,
    output logic [SIZE-1:0]     alu_b,
    input  logic [2*SIZE-1:0]   alu_result,
    input  logic                alu_overflow,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_result,
    output logic                out_overflow,
    output logic [3:0]          out_command,
    output logic                out_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [3:0]      cmd_mem [DEPTH];
    logic [SIZE-1:0] a_mem   [DEPTH];
    logic [SIZE-1:0] b_mem   [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;

    logic            fifo_empty;
    logic            push;
    logic            issue;
    logic            cmd_ok;
    logic [3:0]      head_cmd;

    state_t          state;
    state_t          state_next;

    assign fifo_empty = (count == '0);
    assign head_cmd   = cmd_mem[rd_ptr];

    // in_ready looks only at the registered count, so a pop in a full cycle
    // reopens the FIFO one cycle later and out_ready never reaches in_ready.
    assign in_ready = (count != DEPTH_C);
    assign push     = in_valid && in_ready;

    // An entry issues whenever the output register is free or being drained
    // in this same cycle; that keeps throughput at one result per cycle.
    assign issue = !fifo_empty && (!out_valid || out_ready);

`ifdef ALU_SEQ_CMD_CHECK_EN
    assign cmd_ok = (head_cmd < 4'd12);
`else
    assign cmd_ok = 1'b1;
`endif

    // Rejected commands still occupy their issue slot, they just never
    // enable the ALU.
    assign alu_enable = issue && cmd_ok;

    // The ALU sees the head entry directly; an empty FIFO presents zeros so
    // stale storage never leaks onto the ALU inputs.
    always_comb begin
        alu_command = '0;
        alu_a       = '0;
        alu_b       = '0;
        if (!fifo_empty) begin
            alu_command = head_cmd;
            alu_a       = a_mem[rd_ptr];
            alu_b       = b_mem[rd_ptr];
        end
    end

    // Storage is not reset: an entry is only ever read after being written,
    // and the empty-FIFO zeroing above hides whatever is left behind.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr] <= in_command;
            a_mem[wr_ptr]   <= in_a;
            b_mem[wr_ptr]   <= in_b;
        end
    end

    always_comb begin
        count_next = count;
        case ({push, issue})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers are exactly log2(DEPTH) wide and wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Output register: loads on every issue, clears when drained without a
    // replacement, and otherwise holds so a stalled consumer sees stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_command  <= '0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_command <= head_cmd;
            if (cmd_ok) begin
                out_result   <= alu_result;
                out_overflow <= alu_overflow;
            end else begin
                out_result   <= '0;
                out_overflow <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_CMD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_error <= 1'b0;
        end else if (issue) begin
            out_error <= !cmd_ok;
        end
    end
`else
    assign out_error = 1'b0;
`endif

    // Debug-only state tracking. The datapath never looks at it; issue alone
    // gates the ALU.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end else if (out_valid && !out_ready) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int SIZE  = 8;
    localparam int DEPTH = 4;
    localparam int W2    = 2 * SIZE;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_command;
    logic [SIZE-1:0] in_a;
    logic [SIZE-1:0] in_b;
    logic            alu_enable;
    logic [3:0]      alu_command;
    logic [SIZE-1:0] alu_a;
    logic [SIZE-1:0] alu_b;
    logic [W2-1:0]   alu_result;
    logic            alu_overflow;
    logic            out_valid;
    logic            out_ready;
    logic [W2-1:0]   out_result;
    logic            out_overflow;
    logic [3:0]      out_command;
    logic            out_error;

    int checks = 0;
    int errors = 0;

`ifdef ALU_SEQ_CMD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    alu_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_command   (in_command),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_enable   (alu_enable),
        .alu_command  (alu_command),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_command  (out_command),
        .out_error    (out_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in ALU: returns {overflow, result}
    function automatic logic [W2:0] alu_fn(input logic [3:0] c,
                                           input logic [SIZE-1:0] a,
                                           input logic [SIZE-1:0] b);
        logic [W2-1:0]   r;
        logic            ov;
        logic [SIZE-1:0] t;
        r  = '0;
        ov = 1'b0;
        case (c)
            4'd0:  begin r = W2'(a) + W2'(b); ov = r[SIZE]; end
            4'd1:  begin t = a - b; r = W2'(t); ov = (a < b); end
            4'd2:  begin r = W2'(a) * W2'(b); ov = |r[W2-1:SIZE]; end
            4'd3:  begin t = a & b; r = W2'(t); end
            4'd4:  begin t = a | b; r = W2'(t); end
            4'd5:  begin t = a ^ b; r = W2'(t); end
            4'd6:  begin t = ~a; r = W2'(t); end
            4'd7:  begin r = W2'(a) << 1; ov = a[SIZE-1]; end
            4'd8:  begin t = a >> 1; r = W2'(t); end
            4'd9:  begin r = W2'(a); end
            4'd10: begin r = W2'(b); end
            4'd11: begin r = W2'(a == b); end
            default: begin r = {a, b}; ov = 1'b1; end
        endcase
        return {ov, r};
    endfunction

    assign {alu_overflow, alu_result} = alu_fn(alu_command, alu_a, alu_b);

    // Reference model: a queue of pending operations plus one result slot
    typedef struct packed {
        logic [3:0]      cmd;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
    } op_t;

    op_t           q[$];
    logic          m_valid  = 1'b0;
    logic [W2-1:0] m_result = '0;
    logic          m_ov     = 1'b0;
    logic [3:0]    m_cmd    = '0;
    logic          m_err    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_valid  = 1'b0;
            m_result = '0;
            m_ov     = 1'b0;
            m_cmd    = '0;
            m_err    = 1'b0;
        end else begin : model_step
            bit        can_push;
            bit        iss;
            op_t       h;
            logic [W2:0] f;
            can_push = (q.size() < DEPTH);
            iss      = (q.size() != 0) && (!m_valid || out_ready);
            if (iss) begin
                h       = q.pop_front();
                m_valid = 1'b1;
                m_cmd   = h.cmd;
                if (CHECK_EN && h.cmd >= 4'd12) begin
                    m_result = '0;
                    m_ov     = 1'b0;
                    m_err    = 1'b1;
                end else begin
                    f        = alu_fn(h.cmd, h.a, h.b);
                    m_result = f[W2-1:0];
                    m_ov     = f[W2];
                    m_err    = 1'b0;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (in_valid && can_push) begin
                q.push_back({in_command, in_a, in_b});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : compare
        bit         exp_issue;
        bit         exp_en;
        logic [3:0] hc;
        logic [7:0] ha;
        logic [7:0] hb;
        hc = '0; ha = '0; hb = '0;
        if (q.size() != 0) begin
            hc = q[0].cmd; ha = q[0].a; hb = q[0].b;
        end
        exp_issue = (q.size() != 0) && (!m_valid || out_ready);
        exp_en    = exp_issue && !(CHECK_EN && hc >= 4'd12);
        checkOutput("in_ready",    32'(in_ready),    32'(q.size() < DEPTH));
        checkOutput("alu_enable",  32'(alu_enable),  32'(exp_en));
        checkOutput("alu_command", 32'(alu_command), 32'(hc));
        checkOutput("alu_a",       32'(alu_a),       32'(ha));
        checkOutput("alu_b",       32'(alu_b),       32'(hb));
        checkOutput("out_valid",   32'(out_valid),   32'(m_valid));
        if (m_valid) begin
            checkOutput("out_result",   32'(out_result),   32'(m_result));
            checkOutput("out_overflow", 32'(out_overflow), 32'(m_ov));
            checkOutput("out_command",  32'(out_command),  32'(m_cmd));
            checkOutput("out_error",    32'(out_error),    32'(m_err));
        end
    end

    // Inputs for the cycle that starts at the next rising edge
    task automatic applyStimulus(input logic v, input logic [3:0] c,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic r);
        @(posedge clk);
        #2;
        in_valid   = v;
        in_command = c;
        in_a       = a;
        in_b       = b;
        out_ready  = r;
    endtask

    task automatic midCycle();
        @(negedge clk);
        #1;
    endtask

    op_t fill_ops [6];

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_command = '0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        fill_ops[0] = {4'd0,  8'h01, 8'h02};
        fill_ops[1] = {4'd2,  8'h03, 8'h04};
        fill_ops[2] = {4'd3,  8'hF0, 8'h3C};
        fill_ops[3] = {4'd7,  8'h81, 8'h00};
        fill_ops[4] = {4'd11, 8'h05, 8'h05};
        fill_ops[5] = {4'd1,  8'h09, 8'h09};

        #1 rst_n = 1'b0;
        #1;
        $display("[TB] reset values");
        checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
        checkOutput("rst_alu_enable", 32'(alu_enable), 32'd0);
        checkOutput("rst_out_result", 32'(out_result), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] single operation");
        applyStimulus(1'b1, 4'd0, 8'h12, 8'h34, 1'b1);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("single_issue_en", 32'(alu_enable),  32'd1);
        checkOutput("single_issue_a",  32'(alu_a),       32'h12);
        checkOutput("single_pre_valid",32'(out_valid),   32'd0);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("single_valid",    32'(out_valid),   32'd1);
        checkOutput("single_result",   32'(out_result),  32'h0046);
        checkOutput("single_command",  32'(out_command), 32'd0);
        checkOutput("single_en_after", 32'(alu_enable),  32'd0);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);

        $display("[TB] fill with stalled output");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, fill_ops[i].cmd, fill_ops[i].a, fill_ops[i].b, 1'b0);
        end
        midCycle();
        checkOutput("fill_in_ready",  32'(in_ready),   32'd0);
        checkOutput("fill_out_valid", 32'(out_valid),  32'd1);
        checkOutput("fill_result",    32'(out_result), 32'h0003);
        checkOutput("fill_en",        32'(alu_enable), 32'd0);

        $display("[TB] drain");
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("drain_pop_cycle_ready", 32'(in_ready),   32'd0);
        checkOutput("drain_pop_cycle_en",    32'(alu_enable), 32'd1);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("drain_reopen",   32'(in_ready),    32'd1);
        checkOutput("drain_result2",  32'(out_result),  32'h000C);
        checkOutput("drain_command2", 32'(out_command), 32'd2);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("drain_result4",  32'(out_result),   32'h0102);
        checkOutput("drain_ovf4",     32'(out_overflow), 32'd1);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("drain_result5",  32'(out_result),  32'h0001);
        checkOutput("drain_command5", 32'(out_command), 32'd11);
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("drain_empty",    32'(out_valid),   32'd0);

        $display("[TB] backpressure during back-to-back pushes");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 4'(i % 12), 8'(i * 7), 8'(i + 1), (i % 3) != 1);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        end

        $display("[TB] async reset mid-stream");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd5, 8'(i), 8'hA5, 1'b0);
        end
        @(posedge clk);
        #2;
        checkOutput("prerst_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_mid_valid",   32'(out_valid),   32'd0);
        checkOutput("rst_mid_result",  32'(out_result),  32'd0);
        checkOutput("rst_mid_command", 32'(out_command), 32'd0);
        checkOutput("rst_mid_error",   32'(out_error),   32'd0);
        checkOutput("rst_mid_en",      32'(alu_enable),  32'd0);
        checkOutput("rst_mid_alu_a",   32'(alu_a),       32'd0);
        checkOutput("rst_mid_ready",   32'(in_ready),    32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        end

        $display("[TB] out-of-range command");
        applyStimulus(1'b1, 4'hD, 8'hFF, 8'h01, 1'b1);
        applyStimulus(1'b1, 4'd1, 8'h05, 8'h03, 1'b1);
        midCycle();
        checkOutput("bad_alu_command", 32'(alu_command), 32'hD);
`ifdef ALU_SEQ_CMD_CHECK_EN
        checkOutput("bad_en",          32'(alu_enable),  32'd0);
`else
        checkOutput("bad_en",          32'(alu_enable),  32'd1);
`endif
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("bad_command",     32'(out_command), 32'hD);
`ifdef ALU_SEQ_CMD_CHECK_EN
        checkOutput("bad_error",       32'(out_error),   32'd1);
        checkOutput("bad_result",      32'(out_result),  32'd0);
`else
        checkOutput("bad_error",       32'(out_error),   32'd0);
        checkOutput("bad_result",      32'(out_result),  32'hFF01);
`endif
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        midCycle();
        checkOutput("good_error",      32'(out_error),   32'd0);
        checkOutput("good_result",     32'(out_result),  32'h0002);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        end
        midCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Registered front/back end for the combinational `alu`. It accepts operations over a valid/ready handshake and buffers them in a small FIFO. It issues one operation per cycle to the ALU's `enable`/`command`/`a`/`b` inputs and captures the ALU's `result`/`overflow` into an output register drained by a valid/ready handshake. It sits directly around `alu` in the datapath: it drives all ALU inputs and consumes all ALU outputs.

## Interface
- `SIZE`, 8, operand width; must match the attached `alu` instance.
- `DEPTH`, 4, operation FIFO entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an operation is offered.
- `in_ready` output 1: FIFO can accept; equals `count != DEPTH`.
- `in_command` input 4: ALU command.
- `in_a`, `in_b` input SIZE: operands.
- `alu_enable` output 1: high only in issue cycles.
- `alu_command` output 4: FIFO head command, or 0 when the FIFO is empty.
- `alu_a`, `alu_b` output SIZE: FIFO head operands, or 0 when the FIFO is empty.
- `alu_result` input 2*SIZE: ALU result, combinational from `alu_*`.
- `alu_overflow` input 1: ALU overflow.
- `out_valid` output 1: output register holds a result.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output 2*SIZE: captured result.
- `out_overflow` output 1: captured overflow.
- `out_command` output 4: command that produced `out_result`.
- `out_error` output 1: command rejected (see Configuration).

## Operation
- FIFO: read/write pointers of width log2(DEPTH) that wrap naturally, plus a `count` of width $clog2(DEPTH+1).
- Push when `in_valid & in_ready`.
- `in_ready` depends only on `count`. When the FIFO is full, a same-cycle pop does not reopen it; `in_ready` rises the cycle after the pop.
- Issue condition: `count != 0 && (!out_valid || out_ready)`. In an issue cycle:
  - `alu_enable` = 1.
  - At the clock edge, `alu_result`, `alu_overflow` and the head command load into the output register, `out_valid` is set, and the FIFO pops.
- When `out_valid & out_ready` and there is no issue, `out_valid` clears at the edge.
- When `out_valid & !out_ready`, all `out_*` hold stable.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- A push into an empty FIFO cannot issue in the same cycle; the head becomes visible next cycle.
- FSM (registered `state`):
  - IDLE: `count==0`. Goes to RUN when `count` becomes nonzero.
  - RUN: issue condition true. Stays while the next-cycle issue condition holds. Goes to IDLE when the FIFO drains. Goes to STALL when `out_valid & !out_ready` with entries pending.
  - STALL: `count!=0`, `out_valid & !out_ready`, `alu_enable` = 0. Goes to RUN the cycle after `out_ready` is seen high. During the `out_ready` cycle, issue still happens combinationally by the issue condition, so there is no bubble.
- `state` is observational for debug; the issue condition alone gates `alu_enable`.
- Reset (asynchronous, any time including mid-stream):
  - FIFO empties, pointers and `count` go to 0, state goes to IDLE.
  - `out_valid`, `out_result`, `out_overflow`, `out_command`, `out_error`, `alu_enable` go to 0.
  - `alu_command`/`alu_a`/`alu_b` go to 0.
  - `in_ready` = 1.
  - In-flight operations are discarded.

## Timing
- Latency: an operation pushed at edge N is issued in cycle N+1 (if the output is free), and `out_valid` is high after edge N+1.
- Throughput: one operation per cycle while `out_ready` is held high.
- `alu_*` outputs are combinational from FIFO head registers.
- `alu_result`/`alu_overflow` are sampled at the end of the same issue cycle; the combinational ALU path must close within one cycle.
- There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `ALU_SEQ_CMD_CHECK_EN` defined:
  - Commands 12–15 (beyond the ALU's 12 operations) are still popped and occupy an issue slot.
  - In that slot `alu_enable` = 0, and the output register loads `out_result`=0, `out_overflow`=0, `out_error`=1, `out_command`=that command.
  - Valid commands load `out_error`=0.
- Undefined: every command is forwarded to the ALU unchanged and `out_error` is tied 0.

## Test plan
- Reset then single op: push cmd 0, a=8'h12, b=8'h34 with `out_ready`=1; bench ALU model returns 16'h0046. Expect `alu_enable` high one cycle at N+1, then `out_valid`=1, `out_result`=16'h0046, `out_command`=0 after edge N+1.
- Fill: hold `out_ready`=0 and push 5 ops with DEPTH=4. Expect op1 captured, `out_valid`=1, `in_ready`=0 once `count`=4, state STALL, 6th push refused.
- Drain: from the full stall, raise `out_ready` for 5 cycles. Expect 5 results in push order on consecutive cycles, no bubble, and `in_ready` back to 1 one cycle after the first pop.
- Backpressure mid-stream: toggle `out_ready` 1,0,1 during back-to-back pushes. Expect `out_result` stable while stalled, no loss or duplication, and `count` never exceeding 4.
- Async reset mid-stream: with 3 queued and `out_valid`=1, pulse `rst_n` low between edges. Expect all outputs 0 immediately and `in_ready`=1, with no results after release.
- With `ALU_SEQ_CMD_CHECK_EN`: push cmd 4'hD, a=8'hFF, b=8'h01. Expect `alu_enable` to stay 0, then `out_error`=1, `out_result`=0, `out_command`=4'hD; a following cmd 1 gives `out_error`=0.
